// File: rtl/srl_fifo_reader_if.sv
// rtl/srl_fifo_reader_if.sv - write/read handshake bundle for srl_fifo_reader
interface srl_fifo_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/srl_fifo_reader.sv
// rtl/srl_fifo_reader.sv - shift-register FIFO read through an addressed tap
module srl_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  srl_fifo_reader_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push;
  logic             pop;
  logic [AW-1:0]    addr;

  always_comb begin
    push    = bus.in_valid && (count_q != CW'(DEPTH));
    pop     = bus.out_ready && (count_q != '0);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Shift is the only write path so the chain maps onto SRLs with CE = push.
    sr_d = sr_q;
    if (push) begin
      sr_d[0] = bus.in_data;
      for (int k = 1; k < DEPTH; k++) begin
        sr_d[k] = sr_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Oldest sample sits at count-1; wraps harmlessly when empty.
  assign addr          = AW'(count_q - CW'(1));
  assign bus.out_data  = sr_q[addr];
  assign bus.out_valid = (count_q != '0);
  assign bus.in_ready  = (count_q != CW'(DEPTH));
  assign bus.count     = count_q;
endmodule

// File: tb/tb_srl_fifo_reader.sv
// tb/tb_srl_fifo_reader.sv - randomized and directed checks against a queue model
module tb_srl_fifo_reader;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  srl_fifo_reader_if #(.WIDTH(W), .DEPTH(D)) bus ();

  srl_fifo_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [W-1:0] model_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compares outputs mid-cycle, then advances the model across the next edge.
  task automatic step();
    bit do_push;
    bit do_pop;
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(model_q.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(model_q.size() < D));
    chk("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(model_q[0]));
    end
    do_push = bus.in_valid && (model_q.size() < D);
    do_pop  = bus.out_ready && (model_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(bus.in_data);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    step();
  endtask

  initial begin
    logic [W-1:0] pat;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

    // Fill to full with 0x11*k, then keep offering while full.
    for (int k = 1; k <= D; k++) begin
      pat = W'(8'h11 * k);
      drive(1'b1, pat, 1'b0);
      chk("fill_head", 32'(bus.out_data), 32'h11);
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'hEE, 1'b0);
    chk("full_hold", 32'(bus.count), 32'(D));

    for (int k = 1; k <= D; k++) begin
      chk("drain_order", 32'(bus.out_data), 32'(W'(8'h11 * k)));
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("drained_valid", 32'(bus.out_valid), 32'd0);

    // Steady state at count=5: output is the input stream delayed by 5.
    for (int k = 0; k < 5; k++) drive(1'b1, W'(8'h80 + k), 1'b0);
    for (int k = 5; k < 25; k++) begin
      chk("delay5", 32'(bus.out_data), 32'(W'(8'h80 + k - 5)));
      drive(1'b1, W'(8'h80 + k), 1'b1);
      chk("steady_count", 32'(bus.count), 32'd5);
    end

    // Full with both handshakes offered: only the pop happens.
    while (model_q.size() < D) drive(1'b1, W'($urandom), 1'b0);
    drive(1'b1, 8'h5A, 1'b1);
    chk("full_both_count", 32'(bus.count), 32'(D - 1));
    chk("full_both_ready", 32'(bus.in_ready), 32'd1);

    // Empty with both handshakes offered: only the push happens.
    while (model_q.size() > 0) drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h3C, 1'b1);
    chk("empty_both_count", 32'(bus.count), 32'd1);
    chk("empty_both_data", 32'(bus.out_data), 32'h3C);
    drive(1'b0, 8'h00, 1'b1);

    // Reset mid-burst at count=9 while pushing.
    for (int k = 0; k < 9; k++) drive(1'b1, W'($urandom), 1'b0);
    rst = 1'b1;
    drive(1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 8'hA5, 1'b0);
    chk("post_rst_data", 32'(bus.out_data), 32'hA5);

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int unsigned pv;
      int unsigned pr;
      pv = (ph % 2 == 0) ? 90 : 30;
      pr = (ph % 2 == 0) ? 30 : 90;
      for (int c = 0; c < 300; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        drive($urandom_range(0, 99) < pv, W'($urandom), $urandom_range(0, 99) < pr);
      end
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/srl_fifo_reader.md
# srl_fifo_reader

Shift-register FIFO whose read side is a dynamically addressed tap into a clock-enabled shift chain. Writes push samples into the head of the chain; the reader selects the oldest valid stage by address, so the storage maps onto SRL16E/SRLC32E primitives plus a small occupancy counter. It sits between a bursty producer and a consumer that applies backpressure, and serves as the read-side companion to the plain enabled delay-line tests in the SRL synthesis suite.

## Interface
Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: number of storage stages; 2..32 allowed.

Ports:
- clk  input  1  sole clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  write sample.
- in_valid  input  1  producer has a sample.
- in_ready  output  1  FIFO can accept a sample (count < DEPTH).
- out_data  output  WIDTH  oldest stored sample, read from tap count-1.
- out_valid  output  1  FIFO non-empty (count != 0).
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×WIDTH shift chain sr[0..DEPTH-1]. On push, sr[0] <= in_data and sr[k] <= sr[k-1] for every other stage, in the same cycle. There is no other write path.
- Storage has no reset and no parallel load. This is required so that synthesis maps it onto SRL primitives with the CE pin driven by push.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Read address addr = count-1. out_data = sr[addr] is a combinational mux, giving first-word fall-through.
- When count = 0, out_data is undefined. The bench must not check it.
- Occupancy updates:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged. The oldest sample shifts to index count and is removed; the next oldest lands at index count-1, so addr is still correct.
  - neither: hold.
- in_ready = (count != DEPTH). A push while full is impossible, even if a pop happens in the same cycle. There is no pass-through when full.
- out_valid = (count != 0).
- No overflow or underflow can occur. count never leaves 0..DEPTH.
- Reset:
  - count = 0, so out_valid = 0 and in_ready = 1 from the first cycle after rst is sampled high.
  - Stored data is not cleared; it becomes stale and unreachable.
  - Reset asserted mid-burst discards all contents.
  - rst has priority over push and pop in the same cycle.
- Resource target for WIDTH=8, DEPTH=16: 8 SRL16E for storage, plus only the counter and flag logic in fabric. No FDRE in the data path.

## Timing
- Write to read latency: a sample pushed at edge N is visible on out_data with out_valid = 1 after edge N, provided the FIFO was empty. This is one cycle.
- Throughput: one push and one pop per cycle, sustained indefinitely, when 0 < count < DEPTH.
- in_ready, out_valid and count are functions of registered count only. None of them depends combinationally on in_valid or out_ready.
- out_data depends combinationally on count and the storage only. It does not depend on in_data.
- Full boundary: with count = DEPTH and in_valid = 1 and out_ready = 1, only the pop occurs. The next cycle has count = DEPTH-1 and in_ready = 1.
- Empty boundary: with count = 0 and in_valid = 1 and out_ready = 1, only the push occurs, because out_valid = 0.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0 -> count goes 1, 2, 3; out_data stays 0x11; out_valid = 1.
- Continue pushing 0x44..0x10 until count = 16 (DEPTH=16) -> in_ready = 0; further in_valid is ignored and count holds 16. Then pop 16 times -> outputs 0x11, 0x22, … in order; the cycle after the last pop has out_valid = 0.
- At count = 5, hold in_valid = 1 and out_ready = 1 for 20 cycles with an incrementing pattern -> count stays 5 and outputs are the input stream delayed by exactly 5 samples.
- Full plus simultaneous in_valid and out_ready -> exactly one pop; next cycle count = 15 and in_ready = 1.
- Empty plus simultaneous in_valid and out_ready -> only the push; next cycle count = 1 and out_data = the pushed value.
- Assert rst for one cycle at count = 9 while pushing -> next cycle count = 0, out_valid = 0, in_ready = 1. A fresh push of 0xA5 then appears as out_data = 0xA5. Synthesis check: 8 SRL16E and zero FDRE on the data bits.
